// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Pops one byte at a time from an external FIFO and serialises it as an
// 8N1 UART frame (start bit, 8 data bits LSB first, one stop bit).
// A byte is fetched only when the FSM is idle, enable is high and the FIFO
// reports data; once a frame has started it always runs to completion
// unless nreset is asserted.
//
// CLKS_PER_BIT must be 2 or more.

module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] frame_count
);

    // Baud counter is just wide enough to count 0 .. CLKS_PER_BIT-1.
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic [7:0]        count_next;
    logic              tx_next;
    logic              read_next;
    logic              bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Busy covers the whole fetch/latch/frame sequence.
    assign tx_busy = (state != IDLE);

    // Next-state logic: sequencing through fetch, latch and the ten bit
    // periods; tx_done is asserted during the final stop-bit cycle.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        count_next = frame_count;
        tx_done    = 1'b0;

        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                state_next = LATCH;
            end

            LATCH: begin
                shift_next = fifo_data;
                baud_next  = '0;
                bit_next   = '0;
                state_next = START;
            end

            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    tx_done    = 1'b1;
                    count_next = frame_count + 8'd1;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so that tx and
    // fifo_read_en change on the same edge as the FSM, with no glitches.
    always_comb begin
        tx_next   = 1'b1;
        read_next = (state_next == FETCH);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the idle line immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            frame_count  <= '0;
            tx           <= 1'b1;
            fifo_read_en <= 1'b0;
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_next;
            bit_idx      <= bit_next;
            shift_reg    <= shift_next;
            frame_count  <= count_next;
            tx           <= tx_next;
            fifo_read_en <= read_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader
// Directed bench for uart_tx_fifo_reader with CLKS_PER_BIT = 4.
// Bytes are enqueued into a small FIFO model and into a scoreboard queue;
// a serial monitor decodes every frame on tx and compares it against the
// scoreboard entry it pops.

module tb_uart_tx_fifo_reader;

    localparam int N  = 4;
    localparam int FL = 10 * N;

    logic       clk;
    logic       nreset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] frame_count;

    logic [7:0] fifo_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] exp_q [$];

    int cycle          = 0;
    int check_count    = 0;
    int error_count    = 0;
    int done_pulses    = 0;
    int rd_pulses      = 0;
    int aborted_frames = 0;
    int frames_seen    = 0;
    int last_end_cycle = 0;
    logic check_gap    = 1'b0;

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for gap measurement.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // FIFO model: read data appears the cycle after the pop strobe.
    assign fifo_empty = (rd_ptr == wr_ptr);

    initial fifo_data = 8'h00;

    always @(posedge clk) begin
        if (fifo_read_en === 1'b1) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Enqueue a byte into the FIFO model and the scoreboard together.
    task automatic applyStimulus(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int target);
        int budget;
        int waited;
        budget = (target - done_pulses) * 50 + 50;
        waited = 0;
        while (done_pulses < target && waited < budget) begin
            tick(1);
            waited++;
        end
        if (done_pulses < target) checkOutput("timeout_done", done_pulses, target);
    endtask

    task automatic waitFetch();
        int waited;
        waited = 0;
        while (fifo_read_en !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        if (fifo_read_en !== 1'b1) checkOutput("timeout_fetch", fifo_read_en, 1);
    endtask

    // Protocol invariants: strobe counting, no overlap, no underflow pops.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_pulses++;
        if (fifo_read_en === 1'b1) begin
            rd_pulses++;
            checkOutput("underflow_pop", fifo_empty, 0);
        end
        if (tx_done === 1'b1 || fifo_read_en === 1'b1) begin
            checkOutput("rd_done_overlap", fifo_read_en & tx_done, 0);
        end
    end

    // Serial monitor: captures 10*N samples from the start-bit edge and
    // checks bit values, bit stability and tx_done placement.
    always begin : monitor
        logic [9:0] rx_frame;
        logic [9:0] exp_frame;
        logic [7:0] exp_byte;
        logic       stable;
        logic       done_ok;
        logic       aborted;
        @(negedge clk);
        if (nreset === 1'b1 && tx === 1'b0) begin
            if (check_gap) checkOutput("gap_cycles", cycle - last_end_cycle - 1, 3);
            rx_frame = '0;
            stable   = 1'b1;
            done_ok  = 1'b1;
            aborted  = 1'b0;
            for (int s = 0; s < FL; s++) begin
                if (s > 0) begin
                    @(negedge clk);
                    if (nreset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (s % N == 0) rx_frame[s / N] = tx;
                else if (tx !== rx_frame[s / N]) stable = 1'b0;
                if (tx_busy !== 1'b1) stable = 1'b0;
                if (tx_done !== ((s == FL - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
            end
            if (aborted) begin
                aborted_frames++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                last_end_cycle = cycle;
                frames_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", rx_frame, 10'h000);
                end else begin
                    exp_byte  = exp_q.pop_front();
                    exp_frame = {1'b1, exp_byte, 1'b0};
                    checkOutput("frame_bits", rx_frame, exp_frame);
                    checkOutput("bit_stable", stable, 1);
                    checkOutput("done_position", done_ok, 1);
                end
            end
        end
    end

    initial begin
        logic bad_idle;
        nreset = 1'b1;
        enable = 1'b0;
        #2 nreset = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", tx_busy, 0);
        checkOutput("rst_done", tx_done, 0);
        checkOutput("rst_read_en", fifo_read_en, 0);
        checkOutput("rst_count", frame_count, 0);

        // Single byte 0xA5, queued during reset; fetch on first edge after release.
        $display("[TB] single byte");
        applyStimulus(8'hA5);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        tick(1);
        checkOutput("first_fetch", fifo_read_en, 1);
        checkOutput("fetch_busy", tx_busy, 1);
        checkOutput("fetch_tx", tx, 1);
        tick(1);
        checkOutput("latch_read_en", fifo_read_en, 0);
        checkOutput("latch_tx", tx, 1);
        tick(1);
        checkOutput("start_tx", tx, 0);
        waitDone(1);
        checkOutput("single_count", frame_count, 1);
        checkOutput("single_reads", rd_pulses, 1);

        // Empty FIFO with enable high: nothing happens.
        $display("[TB] empty fifo");
        bad_idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_read_en !== 1'b0) bad_idle = 1'b1;
        end
        checkOutput("empty_idle", bad_idle, 0);
        checkOutput("empty_reads", rd_pulses, 1);

        // Back-to-back 0x00, 0xFF with a 3-cycle gap.
        $display("[TB] back to back");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitDone(2);
        check_gap = 1'b1;
        waitDone(3);
        check_gap = 1'b0;
        checkOutput("b2b_count", frame_count, 3);
        checkOutput("b2b_reads", rd_pulses, 3);

        // Enable dropped during data bit 3 of 0x3C.
        $display("[TB] enable drop");
        applyStimulus(8'h3C);
        applyStimulus(8'h81);
        waitFetch();
        tick(19);
        checkOutput("bit3_level", tx, 1);
        enable = 1'b0;
        waitDone(4);
        tick(60);
        checkOutput("drop_reads", rd_pulses, 4);
        checkOutput("drop_busy", tx_busy, 0);
        checkOutput("drop_count", frame_count, 4);

        // Reset during data bit 5 of 0x81.
        $display("[TB] reset mid-frame");
        enable = 1'b1;
        waitFetch();
        tick(27);
        checkOutput("bit5_level", tx, 0);
        checkOutput("bit5_busy", tx_busy, 1);
        nreset = 1'b0;
        #1;
        checkOutput("async_tx", tx, 1);
        checkOutput("async_busy", tx_busy, 0);
        checkOutput("async_count", frame_count, 0);
        checkOutput("async_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("aborted_frames", aborted_frames, 1);
        applyStimulus(8'h96);
        nreset = 1'b1;
        tick(1);
        checkOutput("post_rst_fetch", fifo_read_en, 1);
        waitDone(5);
        checkOutput("post_rst_count", frame_count, 1);
        checkOutput("post_rst_reads", rd_pulses, 6);

        // 256 frames of 0x55: counter wraps back to 0.
        $display("[TB] counter wrap");
        enable = 1'b0;
        tick(2);
        nreset = 1'b0;
        tick(2);
        nreset = 1'b1;
        checkOutput("wrap_start_count", frame_count, 0);
        for (int i = 0; i < 256; i++) applyStimulus(8'h55);
        enable = 1'b1;
        waitDone(6);
        check_gap = 1'b1;
        waitDone(260);
        checkOutput("wrap_count_255", frame_count, 255);
        waitDone(261);
        checkOutput("wrap_count_0", frame_count, 0);
        check_gap = 1'b0;
        enable = 1'b0;
        tick(5);
        checkOutput("wrap_reads", rd_pulses, 262);
        checkOutput("frames_seen", frames_seen, 261);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200); legal values are 2 or more.
REQ-002 The block SHALL have the following ports, one per line:
- clk  input  1  single system clock; all state changes on its rising edge.
- nreset  input  1  reset; asynchronous, active-low.
- enable  input  1  level; permits starting a new frame.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid one cycle after fifo_read_en.
- fifo_read_en  output  1  one-cycle FIFO pop strobe.
- tx  output  1  UART serial line; idles high.
- tx_busy  output  1  high whenever the FSM is not in IDLE.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- frame_count  output  8  frames completed since reset; wraps modulo 256.

Function
REQ-003 The FSM SHALL have six states: IDLE, FETCH, LATCH, START, DATA, STOP.
REQ-004 IDLE -> FETCH SHALL occur at the clock edge where enable=1 and fifo_empty=0; otherwise the FSM stays in IDLE.
REQ-005 fifo_read_en SHALL be a registered output, high for exactly the one cycle the FSM is in FETCH, and low in every other state.
REQ-006 FETCH -> LATCH SHALL be unconditional after 1 cycle.
REQ-007 In LATCH, fifo_data SHALL be captured into an 8-bit shift register, and the FSM SHALL go to START after 1 cycle.
REQ-008 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-009 DATA SHALL send 8 bits, LSB first, each held on tx for exactly CLKS_PER_BIT cycles; the bit index runs 0..7, then the FSM goes to STOP.
REQ-010 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-011 On the last STOP cycle the block SHALL pulse tx_done for 1 cycle, increment frame_count (255 wraps to 0), and go to IDLE.
REQ-012 tx SHALL be 1 in IDLE, FETCH and LATCH, and tx SHALL be registered (glitch-free).
REQ-013 Frame length SHALL be 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-014 Back-to-back frames (FIFO non-empty, enable=1) SHALL have exactly 3 idle-high cycles (IDLE, FETCH, LATCH) between the last stop-bit cycle and the next start bit.
REQ-015 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reload to 0 on every bit boundary, and never skip or repeat a count.
REQ-016 enable and fifo_empty SHALL be sampled only in IDLE; deasserting enable, or fifo_empty rising, mid-frame SHALL NOT shorten or abort the current frame.
REQ-017 The block SHALL issue at most one fifo_read_en per frame, and SHALL NOT issue one while fifo_empty=1 in IDLE (no underflow pops).
REQ-018 tx_done and fifo_read_en SHALL never be high in the same cycle.

Reset
REQ-019 While nreset=0, the block SHALL immediately, without waiting for clk, force: FSM=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_read_en=0, frame_count=0, shift register=0, baud counter=0, bit index=0.
REQ-020 A reset asserted mid-frame SHALL abandon the frame; the popped byte is lost, and no tx_done or count increment occurs for it.
REQ-021 After nreset deasserts, the first possible IDLE->FETCH transition SHALL be on the first rising clk edge with nreset=1.

Verification (CLKS_PER_BIT=4)
REQ-022 Single byte: FIFO holds 0xA5, enable=1 -> one fifo_read_en pulse; tx sequence 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; tx_done pulses once; frame_count=1.
REQ-023 Back-to-back: FIFO holds 0x00, 0xFF -> two frames with exactly 3 high cycles between the stop bit and the second start bit; frame_count=2; exactly 2 read pulses.
REQ-024 Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_read_en never asserted; tx=1; tx_busy=0.
REQ-025 Enable drop: enable=0 during DATA bit 3 of 0x3C -> frame completes intact; no further frame starts while enable=0 even though FIFO is non-empty.
REQ-026 Reset mid-frame: nreset=0 during DATA bit 5 -> tx=1 and tx_busy=0 before the next clk edge; frame_count=0; next frame after release is a complete, correct frame.
REQ-027 Wrap: 256 frames of 0x55 -> frame_count returns to 0 on the 256th tx_done; every frame is 40 cycles long.
